// File: rtl/regbank_wr_arbiter.sv
// Write-port controller for a REG32-style register bank.
// After reset it zero-fills every register, one per cycle, then arbitrates two
// writeback requesters (0 = ALU, 1 = memory load) round-robin and issues a
// registered one-hot load pulse with the accepted data one cycle after acceptance.
module regbank_wr_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ0_VALID,
  input  logic [ADDR_W-1:0]   REQ0_ADDR,
  input  logic [DATA_W-1:0]   REQ0_DATA,
  output logic                REQ0_READY,
  input  logic                REQ1_VALID,
  input  logic [ADDR_W-1:0]   REQ1_ADDR,
  input  logic [DATA_W-1:0]   REQ1_DATA,
  output logic                REQ1_READY,
  output logic [NUM_REGS-1:0] REG_LOAD,
  output logic [DATA_W-1:0]   REG_D,
  output logic                INIT_BUSY,
  output logic                GRANT_ID
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     count;
  logic [ADDR_W-1:0]     count_nxt;

  logic                  ptr;
  logic                  xfer_p0;
  logic                  gsel_p0;
  logic [ADDR_W-1:0]     addr_p0;
  logic [DATA_W-1:0]     data_p0;

  logic [NUM_REGS-1:0]   load_p1;
  logic [DATA_W-1:0]     data_p1;
  logic                  gid_p1;

  // One-hot decode with the address zero-extended, so out-of-range addresses
  // decode to zero instead of aliasing onto a lower register.
  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] addr,
                                                 input logic skip_zero);
    logic [NUM_REGS-1:0] oh;
    logic [31:0]         addr_ext;
    oh       = '0;
    addr_ext = 32'(addr);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_ext == i[31:0]) oh[i] = 1'b1;
    end
    if (skip_zero) oh[0] = 1'b0;
    return oh;
  endfunction

  // Sweep counter and state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= INIT;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state: walk the sweep count, leave INIT after the last register.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      INIT: begin
        count_nxt = count + ADDR_W'(1);
        if (count == LAST_REG) begin
          state_nxt = RUN;
          count_nxt = '0;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = INIT;
        count_nxt = '0;
      end
    endcase
  end

  // p0: combinational round-robin grant; ptr names the favoured requester on contention.
  assign REQ0_READY = (state == RUN) & REQ0_VALID & (~REQ1_VALID | ~ptr);
  assign REQ1_READY = (state == RUN) & REQ1_VALID & (~REQ0_VALID |  ptr);
  assign xfer_p0    = REQ0_READY | REQ1_READY;
  assign gsel_p0    = REQ1_READY;
  assign addr_p0    = gsel_p0 ? REQ1_ADDR : REQ0_ADDR;
  assign data_p0    = gsel_p0 ? REQ1_DATA : REQ0_DATA;

  // p1: register the accepted write; load pulse lasts one cycle, data/id hold.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      load_p1 <= '0;
      data_p1 <= '0;
      gid_p1  <= 1'b0;
      ptr     <= 1'b0;
    end else if (xfer_p0) begin
      load_p1 <= decode(addr_p0, ZERO_REG);
      data_p1 <= data_p0;
      gid_p1  <= gsel_p0;
      ptr     <= ~gsel_p0;
    end else begin
      load_p1 <= '0;
    end
  end

  // During the sweep the load vector follows the count directly so register 0
  // loads in the first cycle after reset release; reset forces it low at once.
  assign REG_LOAD  = RESET ? '0 :
                     (state == INIT) ? decode(count, 1'b0) : load_p1;
  assign REG_D     = data_p1;
  assign GRANT_ID  = gid_p1;
  assign INIT_BUSY = (state == INIT);

endmodule
